ula_seq: RTL and testbench

Sequential, parametrised successor of the combinational ULA. It executes one opcode per transaction over a valid/ready handshake. Results and the 5-bit rflags are registered. Single-cycle ops complete in 1 cycle; signed DIV uses an iterative restoring divider. It sits between the register-file read stage and write-back, and it stalls issue via in_ready.

---
 rtl/ula_seq_pkg.sv | 33 +++
 rtl/ula_seq_div_iter.sv | 66 ++++++
 rtl/ula_seq.sv | 187 ++++++++++++++++++
 tb/tb_ula_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ula_seq_pkg.sv
// params_proc: shared constants for the sequential ULA (opcodes, flag bit
// positions, default widths and the controller state encoding).
package params_proc;

    localparam int DATA_WIDTH_DEF   = 16;
    localparam int OPCODE_WIDTH_DEF = 4;

    // Defined opcodes occupy 0..7, so the low three opcode bits select the operation.
    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_AND = 3'd4,
        OP_OR  = 3'd5,
        OP_NOT = 3'd6,
        OP_CMP = 3'd7
    } op_e;

    localparam int FLAG_WIDTH = 5;
    localparam int FLAG_OVF   = 4;
    localparam int FLAG_ABV   = 3;
    localparam int FLAG_EQ    = 2;
    localparam int FLAG_BLW   = 1;
    localparam int FLAG_ERR   = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV_ITER,
        ST_DONE
    } state_e;

endpackage

// File: rtl/ula_seq_div_iter.sv
// ula_div_iter: unsigned restoring divider, one quotient bit per cycle.
// Operands load on start_i; done_o flags the cycle of the last iteration and
// quotient_o then carries the final quotient (valid combinationally that cycle).
module ula_div_iter #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] quotient_o
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  dvs_q;
    logic [CW-1:0] cnt_q;
    logic          active_q;
    logic [W:0]    shifted;
    logic [W:0]    diff;
    logic          fits;

    // One shift/subtract step: the remainder stays below the divisor, so the
    // top bit of the (W+1)-bit difference is a valid sign for the trial subtract.
    always_comb begin
        shifted = {rem_q, quo_q[W-1]};
        diff    = shifted - {1'b0, dvs_q};
        fits    = !diff[W];
        rem_d   = fits ? diff[W-1:0] : shifted[W-1:0];
        quo_d   = {quo_q[W-2:0], fits};
    end

    assign done_o     = active_q && (cnt_q == CW'(1));
    assign quotient_o = quo_d;

    // Iteration registers: load on start, then step until the counter runs out.
    always_ff @(posedge clk) begin
        // NOTE: only active_q/cnt_q need reset for correctness; the datapath is
        // cleared too so an aborted divide leaves nothing stale behind.
        if (rst) begin
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start_i) begin
            rem_q    <= '0;
            quo_q    <= dividend_i;
            dvs_q    <= divisor_i;
            cnt_q    <= CW'(DATA_WIDTH);
            active_q <= 1'b1;
        end else if (active_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ula_seq.sv
// ula_seq: sequential ULA with valid/ready handshake, registered result and
// rflags, and an iterative signed divider. Optional build macro ULA_SAT_EN
// makes ADD/SUB/MUL saturate to MAX/MIN instead of wrapping on overflow.
module ula_seq
    import params_proc::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int OPCODE_WIDTH = OPCODE_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [DATA_WIDTH-1:0]   data1,
    input  logic [DATA_WIDTH-1:0]   data2,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out,
    output logic [FLAG_WIDTH-1:0]   rflags,
    output logic                    busy
);
    localparam int W = DATA_WIDTH;
`ifdef ULA_SAT_EN
    localparam logic [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
`endif

    state_e                state_q, state_d;
    logic [W-1:0]          out_q, out_d;
    logic [FLAG_WIDTH-1:0] rflags_q, rflags_d;
    logic                  neg_q, neg_d;

    logic signed [W-1:0]   a, b;
    logic                  op_defined;
    op_e                   op;
    logic signed [W:0]     sum_ext, dif_ext;
    logic [2*W-1:0]        prod;
    logic                  prod_ovf;
    logic [W-1:0]          alu_out;
    logic [FLAG_WIDTH-1:0] alu_flags;
    logic                  alu_ovf;

    logic                  div_start, div_done;
    logic [W-1:0]          abs_a, abs_b, div_quo, div_res;
    logic [FLAG_WIDTH-1:0] div_flags;

    assign a          = $signed(data1);
    assign b          = $signed(data2);
    assign op_defined = ((opcode >> 3) == '0);
    assign op         = op_e'(opcode[2:0]);
    assign sum_ext    = {a[W-1], a} + {b[W-1], b};
    assign dif_ext    = {a[W-1], a} - {b[W-1], b};
    assign prod       = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
    // The product fits the signed range only if its top W+1 bits are all equal.
    assign prod_ovf   = !((&prod[2*W-1:W-1]) || (~|prod[2*W-1:W-1]));
    assign abs_a      = data1[W-1] ? -data1 : data1;
    assign abs_b      = data2[W-1] ? -data2 : data2;

    // Single-cycle result and flags for every op except a nonzero divide.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path through the case statement can leave a latch behind.
        alu_out   = '0;
        alu_flags = '0;
        alu_ovf   = 1'b0;
        if (!op_defined) begin
            alu_flags[FLAG_ERR] = 1'b1;
        end else begin
            case (op)
                OP_ADD: begin
                    alu_out = sum_ext[W-1:0];
                    alu_ovf = sum_ext[W] ^ sum_ext[W-1];
                end
                OP_SUB: begin
                    alu_out = dif_ext[W-1:0];
                    alu_ovf = dif_ext[W] ^ dif_ext[W-1];
                end
                OP_MUL: begin
                    alu_out = prod[W-1:0];
                    alu_ovf = prod_ovf;
                end
                OP_DIV: alu_flags[FLAG_ERR] = 1'b1;  // only reached for divide by zero
                OP_AND: alu_out = data1 & data2;
                OP_OR:  alu_out = data1 | data2;
                OP_NOT: alu_out = ~data1;
                OP_CMP: begin
                    alu_flags[FLAG_ABV] = (a > b);
                    alu_flags[FLAG_EQ]  = (a == b);
                    alu_flags[FLAG_BLW] = (a < b);
                end
                default: ;
            endcase
`ifdef ULA_SAT_EN
            // Clamp toward the sign of the exact (unwrapped) result.
            if (alu_ovf) begin
                if (op == OP_MUL)      alu_out = prod[2*W-1] ? MIN_VAL : MAX_VAL;
                else if (op == OP_ADD) alu_out = sum_ext[W]  ? MIN_VAL : MAX_VAL;
                else                   alu_out = dif_ext[W]  ? MIN_VAL : MAX_VAL;
            end
`endif
            if (op != OP_CMP && op != OP_DIV) begin
                alu_flags[FLAG_OVF] = alu_ovf;
                alu_flags[FLAG_EQ]  = (alu_out == '0);
            end
        end
    end

    // Sign correction of the unsigned quotient; only MIN/-1 can overflow.
    always_comb begin
        div_res             = neg_q ? -div_quo : div_quo;
        div_flags           = '0;
        div_flags[FLAG_OVF] = !neg_q && div_quo[W-1];
        div_flags[FLAG_EQ]  = (div_res == '0);
    end

    ula_div_iter #(
        .DATA_WIDTH (W)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .dividend_i (abs_a),
        .divisor_i  (abs_b),
        .done_o     (div_done),
        .quotient_o (div_quo)
    );

    // Controller next state: accept in IDLE, iterate a divide, hold in DONE.
    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        rflags_d  = rflags_q;
        neg_d     = neg_q;
        div_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (op_defined && op == OP_DIV && data2 != '0) begin
                        div_start = 1'b1;
                        neg_d     = data1[W-1] ^ data2[W-1];
                        state_d   = ST_DIV_ITER;
                    end else begin
                        out_d    = alu_out;
                        rflags_d = alu_flags;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_DIV_ITER: begin
                if (div_done) begin
                    out_d    = div_res;
                    rflags_d = div_flags;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, result and flag registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q  <= ST_IDLE;
            out_q    <= '0;
            rflags_q <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            rflags_q <= rflags_d;
            neg_q    <= neg_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_DIV_ITER);
    assign out       = out_q;
    assign rflags    = rflags_q;

endmodule

// File: tb/tb_ula_seq.sv
// Directed bench for ula_seq (DATA_WIDTH=16): handshake latency, arithmetic
// results, flags, backpressure and reset during a divide.
module tb_ula_seq;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, MUL = 4'd2, DIV = 4'd3;
    localparam logic [3:0] AND = 4'd4, OR  = 4'd5, NOT = 4'd6, CMP = 4'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  opcode = '0;
    logic [15:0] data1 = '0;
    logic [15:0] data2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out;
    logic [4:0]  rflags;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    int lat;
    int busy_cnt;
    logic rdy_seen;
    logic valid_seen;

    ula_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .data1     (data1),
        .data2     (data2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .rflags    (rflags),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Issue one op, scramble the inputs after acceptance, and wait for out_valid.
    task automatic run_op(input logic [3:0] op, input logic [15:0] d1, input logic [15:0] d2);
        @(negedge clk);
        opcode   = op;
        data1    = d1;
        data2    = d2;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        data1    = ~d1;
        data2    = ~d2;
        opcode   = 4'd5;
        lat      = 0;
        busy_cnt = 0;
        rdy_seen = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) busy_cnt++;
            if (in_ready) rdy_seen = 1'b1;
        end while (!out_valid && lat < 100);
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [3:0] op, input logic [15:0] d1,
                         input logic [15:0] d2, input logic [15:0] exp_out,
                         input logic [4:0] exp_flags, input int exp_lat);
        run_op(op, d1, d2);
        check({tag, ".out"}, out, exp_out);
        check({tag, ".flags"}, rflags, exp_flags);
        check({tag, ".lat"}, lat, exp_lat);
        ack();
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst.out_valid", out_valid, 0);
        check("rst.in_ready", in_ready, 1);
        check("rst.busy", busy, 0);
        check("rst.out", out, 0);
        check("rst.rflags", rflags, 0);

        // ADD overflow boundary
`ifdef ULA_SAT_EN
        do_op("add_ovf", ADD, 16'h7FFF, 16'h0001, 16'h7FFF, 5'b10000, 1);
`else
        do_op("add_ovf", ADD, 16'h7FFF, 16'h0001, 16'h8000, 5'b10000, 1);
`endif

        // Signed division, truncating toward zero
        run_op(DIV, 16'hFFFB, 16'h0002);
        check("div_m5_2.out", out, 16'hFFFE);
        check("div_m5_2.flags", rflags, 5'b00000);
        check("div_m5_2.lat", lat, 17);
        check("div_m5_2.busy_cycles", busy_cnt, 16);
        check("div_m5_2.in_ready_low", rdy_seen, 0);
        ack();
        run_op(DIV, 16'h0005, 16'hFFFD);
        check("div_5_m3.out", out, 16'hFFFF);
        check("div_5_m3.flags", rflags, 5'b00000);
        check("div_5_m3.lat", lat, 17);
        check("div_5_m3.busy_cycles", busy_cnt, 16);
        ack();
        do_op("div_100_7", DIV, 16'd100, 16'd7, 16'd14, 5'b00000, 17);
        do_op("div_m7_m2", DIV, 16'hFFF9, 16'hFFFE, 16'h0003, 5'b00000, 17);
        do_op("div_by0", DIV, 16'd6, 16'd0, 16'h0000, 5'b00001, 1);
        do_op("div_min_m1", DIV, 16'h8000, 16'hFFFF, 16'h8000, 5'b10000, 17);

        // Signed compare
        do_op("cmp_below", CMP, 16'hFFFB, 16'h0008, 16'h0000, 5'b00010, 1);
        do_op("cmp_above", CMP, 16'h0005, 16'hFFF8, 16'h0000, 5'b01000, 1);
        do_op("cmp_equal", CMP, 16'h0005, 16'h0005, 16'h0000, 5'b00100, 1);

        // SUB / MUL
        do_op("sub_plain", SUB, 16'd3, 16'd5, 16'hFFFE, 5'b00000, 1);
        do_op("mul_neg", MUL, 16'hFFFC, 16'd3, 16'hFFF4, 5'b00000, 1);
`ifdef ULA_SAT_EN
        do_op("mul_ovf", MUL, 16'd300, 16'd300, 16'h7FFF, 5'b10000, 1);
`else
        do_op("mul_ovf", MUL, 16'd300, 16'd300, 16'h5F90, 5'b10000, 1);
`endif

        // Bitwise ops
        do_op("and", AND, 16'h0F0F, 16'h00FF, 16'h000F, 5'b00000, 1);
        do_op("and_zero", AND, 16'hF0F0, 16'h0F0F, 16'h0000, 5'b00100, 1);
        do_op("or", OR, 16'hF000, 16'h000F, 16'hF00F, 5'b00000, 1);
        do_op("not", NOT, 16'hFFFF, 16'h1234, 16'h0000, 5'b00100, 1);

        // Undefined opcode
        run_op(4'd9, 16'h1234, 16'h5678);
        check("undef.out", out, 0);
        check("undef.err", rflags[0], 1);
        check("undef.lat", lat, 1);
        ack();

        // SUB overflow leaves nonzero out/rflags ahead of the reset test
`ifdef ULA_SAT_EN
        do_op("sub_ovf", SUB, 16'h8000, 16'h0001, 16'h8000, 5'b10000, 1);
`else
        do_op("sub_ovf", SUB, 16'h8000, 16'h0001, 16'h7FFF, 5'b10000, 1);
`endif

        // Reset in the 8th DIV_ITER cycle aborts the divide
        @(negedge clk);
        opcode   = DIV;
        data1    = 16'd100;
        data2    = 16'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("rst_mid.busy_before", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_mid.out_valid", out_valid, 0);
        check("rst_mid.rflags", rflags, 0);
        check("rst_mid.in_ready", in_ready, 1);
        check("rst_mid.busy", busy, 0);
        valid_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) valid_seen = 1'b1;
        end
        check("rst_mid.no_result", valid_seen, 0);
        do_op("add_after_rst", ADD, 16'd5, 16'd10, 16'd15, 5'b00000, 1);

        // Backpressure: result held, no acceptance until after out_ready
        run_op(MUL, 16'd5, 16'd2);
        check("bp.out", out, 16'd10);
        check("bp.lat", lat, 1);
        opcode   = ADD;
        data1    = 16'd1;
        data2    = 16'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp.hold_out", out, 16'd10);
            check("bp.hold_in_ready", in_ready, 0);
            check("bp.hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("bp.release_valid", out_valid, 0);
        check("bp.release_in_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("bp.next_valid", out_valid, 1);
        check("bp.next_out", out, 16'd2);
        ack();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
